neopixel_tx: RTL and testbench

- Parametrised WS2812-class single-wire LED serializer. It accepts BITS-wide pixel words (default 24-bit GRB) over a valid/ready handshake and emits them MSB first as timed high/low pulses on d_out.
- Appends the strip latch/reset low period after a word flagged last, and after every reset.
- Sits between the pixel frame sequencer and the PMod output pin. Successor to the single-bit pixel writer: multi-bit words, cycle-exact timing derived from the clock rate, frame latch handling.

---
 rtl/neopixel_tx.sv | 165 ++++++++++++++++
 tb/tb_neopixel_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_tx.sv
// neopixel_tx: WS2812-class single-wire LED serializer.
// Accepts BITS-wide pixel words over valid/ready and emits them MSB first as
// cycle-exact high/low pulses on d_out, followed by a strip latch period when
// the word is flagged last, and always after reset.
//
// Ports:
//   CLK     in   system clock
//   RESETN  in   synchronous active-low reset
//   data    in   pixel word, MSB transmitted first
//   last    in   word ends a frame, latch period follows
//   valid   in   data/last valid
//   ready   out  block accepts a word this cycle
//   busy    out  high whenever not idle
//   d_out   out  serial line to LED strip
module neopixel_tx #(
    parameter int unsigned CLK_HZ  = 12_000_000,
    parameter int unsigned BITS    = 24,
    parameter int unsigned T0H_NS  = 400,
    parameter int unsigned T1H_NS  = 800,
    parameter int unsigned TBIT_NS = 1250,
    parameter int unsigned TRES_US = 60
) (
    input  logic            CLK,
    input  logic            RESETN,
    input  logic [BITS-1:0] data,
    input  logic            last,
    input  logic            valid,
    output logic            ready,
    output logic            busy,
    output logic            d_out
);

    // Cycle counts derived from the clock rate, rounded to nearest
    localparam int unsigned KHZ     = CLK_HZ / 1000;
    localparam int unsigned T0H     = (KHZ * T0H_NS + 500_000) / 1_000_000;
    localparam int unsigned T1H     = (KHZ * T1H_NS + 500_000) / 1_000_000;
    localparam int unsigned TBIT    = (KHZ * TBIT_NS + 500_000) / 1_000_000;
    localparam int unsigned TRES    = KHZ * TRES_US / 1000;
    localparam int unsigned CNT_MAX = (TRES > TBIT) ? TRES : TBIT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BCNT_W  = $clog2(BITS);

    if (!(T0H >= 1 && T0H < T1H && T1H < TBIT && TRES >= 1 && BITS >= 2)) begin : g_bad_params
        $error("neopixel_tx: timing parameters violate 1 <= T0H < T1H < TBIT, TRES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HIGH  = 2'd1,
        S_LOW   = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BITS-1:0]     shift_q, shift_d;
    logic [BCNT_W-1:0]   bit_q, bit_d;
    logic                last_q, last_d;
    logic                restart_q, restart_d;
    logic                d_out_q, d_out_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    hi_len_c;
    logic [CNT_W-1:0]    lo_len_c;

    // Pulse lengths for the bit currently at the shift register MSB
    always_comb begin
        hi_len_c = shift_q[BITS-1] ? CNT_W'(T1H) : CNT_W'(T0H);
        lo_len_c = CNT_W'(TBIT) - hi_len_c;
    end

    // Next-state, counters and registered-output inputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        last_d    = last_q;
        restart_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (valid && ready_q) begin
                    shift_d = data;
                    last_d  = last;
                    bit_d   = BCNT_W'(BITS - 1);
                    cnt_d   = '0;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (cnt_q == hi_len_c - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOW: begin
                if (cnt_q == lo_len_c - CNT_W'(1)) begin
                    cnt_d = '0;
                    if (bit_q != '0) begin
                        shift_d = {shift_q[BITS-2:0], 1'b0};
                        bit_d   = bit_q - BCNT_W'(1);
                        state_d = S_HIGH;
                    end else begin
                        state_d = last_q ? S_LATCH : S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LATCH: begin
                // The first cycle after reset release starts the latch count,
                // so a reset always yields a full TRES-cycle latch afterwards.
                if (restart_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(TRES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_LATCH;
                cnt_d   = '0;
            end
        endcase

        d_out_d = (state_d == S_HIGH);
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset into LATCH
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q   <= S_LATCH;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            last_q    <= 1'b0;
            restart_q <= 1'b1;
            d_out_q   <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            last_q    <= last_d;
            restart_q <= restart_d;
            d_out_q   <= d_out_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign d_out = d_out_q;
    assign ready = ready_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_neopixel_tx.sv
// Testbench for neopixel_tx: a default 24-bit instance and a 32-bit/24 MHz
// instance, checked against a waveform model built from the pulse rules.
module tb_neopixel_tx;

    localparam int unsigned A_BITS = 24, A_T0H = 5,  A_T1H = 10, A_TBIT = 15, A_TRES = 720;
    localparam int unsigned B_BITS = 32, B_T0H = 10, B_T1H = 19, B_TBIT = 30, B_TRES = 1440;
    localparam int LIMIT = 5000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] data_a;
    logic [31:0] data_b;
    logic        last_a, last_b, valid_a, valid_b;
    logic        ready_a, busy_a, dout_a;
    logic        ready_b, busy_b, dout_b;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    neopixel_tx u_dut_a (
        .CLK    (clk),
        .RESETN (rst_n),
        .data   (data_a),
        .last   (last_a),
        .valid  (valid_a),
        .ready  (ready_a),
        .busy   (busy_a),
        .d_out  (dout_a)
    );

    neopixel_tx #(.CLK_HZ(24_000_000), .BITS(32)) u_dut_b (
        .CLK    (clk),
        .RESETN (rst_n),
        .data   (data_b),
        .last   (last_b),
        .valid  (valid_b),
        .ready  (ready_b),
        .busy   (busy_b),
        .d_out  (dout_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_rdy(input bit b);
        return b ? ready_b : ready_a;
    endfunction
    function automatic logic get_busy(input bit b);
        return b ? busy_b : busy_a;
    endfunction
    function automatic logic get_dout(input bit b);
        return b ? dout_b : dout_a;
    endfunction

    task automatic drive(input bit b, input logic v, input logic [31:0] d, input logic l);
        if (b) begin
            valid_b = v; data_b = d; last_b = l;
        end else begin
            valid_a = v; data_a = d[23:0]; last_a = l;
        end
    endtask

    // Expected samples of one bit period, first sample in the top position:
    // the line is high for the first T0H/T1H cycles, low for the rest.
    function automatic logic [63:0] exp_window(input bit b, input logic v);
        int unsigned hi;
        int unsigned tb;
        hi = v ? (b ? B_T1H : A_T1H) : (b ? B_T0H : A_T0H);
        tb = b ? B_TBIT : A_TBIT;
        return ((64'(1) << hi) - 64'(1)) << (tb - hi);
    endfunction

    // mode 0: valid low while sending; 1: random junk on inputs; 2: hold next word valid
    task automatic send(input bit b, input logic [31:0] word, input logic lst, input int mode,
                        input logic [31:0] nword, input logic nlast);
        int          nb;
        int          tb;
        int          guard;
        int          busy_err;
        logic [63:0] win;
        nb = b ? int'(B_BITS) : int'(A_BITS);
        tb = b ? int'(B_TBIT) : int'(A_TBIT);
        drive(b, 1'b1, word, lst);
        guard = 0;
        while (!get_rdy(b) && guard < LIMIT) begin
            tick();
            guard++;
        end
        check("send_ready", 64'(get_rdy(b)), 64'(1));
        tick();
        if (mode == 2) drive(b, 1'b1, nword, nlast);
        else           drive(b, 1'b0, $urandom, 1'($urandom));
        busy_err = 0;
        for (int i = nb - 1; i >= 0; i--) begin
            win = '0;
            for (int c = 0; c < tb; c++) begin
                win = {win[62:0], get_dout(b)};
                if (get_busy(b) !== 1'b1 || get_rdy(b) !== 1'b0) busy_err++;
                if (mode == 1) drive(b, 1'($urandom), $urandom, 1'($urandom));
                tick();
            end
            check($sformatf("bit%0d", i), win, exp_window(b, word[i]));
        end
        check("busy_word", 64'(busy_err), 64'(0));
        if (mode == 1) drive(b, 1'b0, $urandom, 1'($urandom));
    endtask

    // Counts cycles with ready low (line must stay low, busy high) until ready
    task automatic count_low(input bit b, input string tag, input int exp);
        int m;
        int derr;
        m = 0;
        derr = 0;
        while (!get_rdy(b) && m < LIMIT) begin
            if (get_dout(b) !== 1'b0) derr++;
            if (get_busy(b) !== 1'b1) derr++;
            m++;
            tick();
        end
        check(tag, 64'(m), 64'(exp));
        check({tag, "_quiet"}, 64'(derr), 64'(0));
        check({tag, "_busy"}, 64'(get_busy(b)), 64'(0));
    endtask

    initial begin
        int          gap;
        int          nres;
        logic [31:0] w;
        logic        l;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0);
        repeat (3) tick();
        check("rst_dout", 64'(dout_a), 64'(0));
        check("rst_ready", 64'(ready_a), 64'(0));
        check("rst_busy", 64'(busy_a), 64'(1));
        check("rst_busy_b", 64'(busy_b), 64'(1));

        // Full latch after reset release
        rst_n = 1'b1;
        tick();
        count_low(1'b0, "rst_latch", int'(A_TRES));

        // Single word, no latch
        send(1'b0, 32'h00A50000, 1'b0, 0, '0, 1'b0);
        count_low(1'b0, "a50000_end", 0);

        // Back-to-back words with valid held, second one ends the frame
        send(1'b0, 32'h00FFFFFF, 1'b0, 2, 32'h0, 1'b1);
        check("gap_ready", 64'(ready_a), 64'(1));
        check("gap_dout", 64'(dout_a), 64'(0));
        send(1'b0, 32'h0, 1'b1, 0, '0, 1'b0);
        count_low(1'b0, "frame_latch", int'(A_TRES));

        // Random words with junk on the inputs while busy
        for (int k = 0; k < 8; k++) begin
            gap = int'($urandom_range(0, 5));
            repeat (gap) tick();
            w = $urandom;
            l = ($urandom_range(0, 3) == 0);
            send(1'b0, w, l, 1, '0, 1'b0);
            count_low(1'b0, $sformatf("rand%0d_end", k), l ? int'(A_TRES) : 0);
        end

        // Reset in the middle of a word
        drive(1'b0, 1'b1, $urandom, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        check("mid_start", 64'(dout_a), 64'(1));
        repeat (99) tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_dout", 64'(dout_a), 64'(0));
        check("mid_rst_ready", 64'(ready_a), 64'(0));
        check("mid_rst_busy", 64'(busy_a), 64'(1));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        count_low(1'b0, "mid_latch", int'(A_TRES));
        nres = 0;
        for (int c = 0; c < 400; c++) begin
            if (dout_a !== 1'b0 || ready_a !== 1'b1) nres++;
            tick();
        end
        check("no_resume", 64'(nres), 64'(0));

        // 32-bit instance at 24 MHz
        send(1'b1, 32'h80000001, 1'b0, 0, '0, 1'b0);
        count_low(1'b1, "b_end", 0);
        w = $urandom;
        send(1'b1, w, 1'b1, 1, '0, 1'b0);
        count_low(1'b1, "b_latch", int'(B_TRES));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
